// File: rtl/tl45_pkg.sv
// Shared opcode, branch-condition and flag definitions for the TL45 execute stage.
package tl45_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        OP_NOP    = 5'h00,
        OP_ADD    = 5'h01,
        OP_SUB    = 5'h02,
        OP_MUL    = 5'h03,
        OP_OR     = 5'h04,
        OP_XOR    = 5'h05,
        OP_AND    = 5'h06,
        OP_SHL    = 5'h07,
        OP_SHR    = 5'h08,
        OP_BRANCH = 5'h0C
    } opcode_e;

    typedef enum logic [3:0] {
        JC_ALWAYS = 4'h0,
        JC_Z      = 4'h1,
        JC_NZ     = 4'h2,
        JC_C      = 4'h3,
        JC_NC     = 4'h4,
        JC_N      = 4'h5,
        JC_NN     = 4'h6,
        JC_V      = 4'h7,
        JC_NV     = 4'h8
    } jmp_cond_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Single-cycle ops that write a result and update Z/N/C/V.
    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_SHL, OP_SHR: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tl45_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Keeps the low 32 bits of the unsigned product; abortable at any time.
module tl45_iter_mul
    import tl45_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            hold_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int unsigned STEPS = XLEN / MUL_STEP;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e            state_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic              final_cycle;

    function automatic logic [XLEN-1:0] partial(input logic [XLEN-1:0] mcand,
                                                input logic [MUL_STEP-1:0] bits);
        logic [XLEN-1:0] sum;
        sum = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (bits[i]) sum = sum + (mcand << i);
        end
        return sum;
    endfunction

    // count_q is the number of cycles left including the current one; the start
    // cycle counts as STEPS, so the first step is folded into the start edge and
    // the last step is added combinationally on the final cycle.
    assign final_cycle = (state_q == S_MUL) && (count_q == CW'(1));
    assign busy_o      = ((state_q == S_IDLE) && start_i && !abort_i) ||
                         ((state_q == S_MUL) && (count_q > CW'(1)));
    assign done_o      = final_cycle;
    assign product_o   = acc_q + partial(mcand_q, mplier_q[MUL_STEP-1:0]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q  <= S_MUL;
                        count_q  <= CW'(STEPS - 1);
                        acc_q    <= partial(a_i, b_i[MUL_STEP-1:0]);
                        mcand_q  <= a_i << MUL_STEP;
                        mplier_q <= b_i >> MUL_STEP;
                    end
                end
                S_MUL: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                    end else if (!final_cycle) begin
                        acc_q    <= acc_q + partial(mcand_q, mplier_q[MUL_STEP-1:0]);
                        mcand_q  <= mcand_q << MUL_STEP;
                        mplier_q <= mplier_q >> MUL_STEP;
                        count_q  <= count_q - CW'(1);
                    end else if (!hold_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tl45_alu_stage.sv
// TL45 execute stage: ALU, iterative MUL, flags, branch resolution, operand
// forwarding and the ALU buffer feeding memory/writeback.
module tl45_alu_stage
    import tl45_pkg::*;
#(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    output logic        o_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_flush,
    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [3:0]  i_jmp_cond,
    input  logic [31:0] i_sr1_val,
    input  logic [31:0] i_sr2_val,
    input  logic [31:0] i_target_address_offset,
    input  logic [31:0] i_pc,
    output logic [3:0]  o_of1_reg,
    output logic [31:0] o_of1_data,
    output logic [3:0]  o_of2_reg,
    output logic [31:0] o_of2_data,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_target,
    output logic [4:0]  o_opcode,
    output logic [3:0]  o_dr,
    output logic [31:0] o_value,
    output logic [3:0]  o_flags
);

    logic [4:0]  opcode_q;
    logic [3:0]  dr_q;
    logic [31:0] value_q;
    flags_t      flags_q, flags_d;

    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    logic [31:0] result;
    logic        writes;
    logic [32:0] sum;
    logic [31:0] diff;
    logic        cond_true;
    logic        advance;
    logic        branch_taken;

    assign mul_start = !i_reset && (i_opcode == OP_MUL);

    tl45_iter_mul #(.MUL_STEP(MUL_STEP)) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .start_i   (mul_start),
        .abort_i   (i_pipe_flush),
        .hold_i    (i_pipe_stall),
        .a_i       (i_sr1_val),
        .b_i       (i_sr2_val),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        result  = '0;
        writes  = 1'b0;
        flags_d = flags_q;
        sum     = {1'b0, i_sr1_val} + {1'b0, i_sr2_val};
        diff    = i_sr1_val - i_sr2_val;
        case (i_opcode)
            OP_ADD: begin
                result    = sum[31:0];
                flags_d.c = sum[32];
                flags_d.v = (i_sr1_val[31] == i_sr2_val[31]) && (sum[31] != i_sr1_val[31]);
            end
            OP_SUB: begin
                result    = diff;
                flags_d.c = i_sr1_val < i_sr2_val;
                flags_d.v = (i_sr1_val[31] != i_sr2_val[31]) && (diff[31] != i_sr1_val[31]);
            end
            OP_OR:   result = i_sr1_val | i_sr2_val;
            OP_XOR:  result = i_sr1_val ^ i_sr2_val;
            OP_AND:  result = i_sr1_val & i_sr2_val;
            OP_SHL:  result = i_sr1_val << i_sr2_val[4:0];
            OP_SHR:  result = i_sr1_val >> i_sr2_val[4:0];
            OP_MUL: begin
                if (mul_done) begin
                    result = mul_product;
                    writes = 1'b1;
                end
            end
            default: ;
        endcase
        if (is_alu_op(i_opcode)) begin
            writes    = 1'b1;
            flags_d.z = (result == '0);
            flags_d.n = result[31];
            if (i_opcode != OP_ADD && i_opcode != OP_SUB) begin
                flags_d.c = 1'b0;
                flags_d.v = 1'b0;
            end
        end
    end

    // Conditions are evaluated against the flag register, i.e. the result of
    // the instruction already sitting in the buffer.
    always_comb begin
        cond_true = 1'b0;
        case (i_jmp_cond)
            JC_ALWAYS: cond_true = 1'b1;
            JC_Z:      cond_true = flags_q.z;
            JC_NZ:     cond_true = !flags_q.z;
            JC_C:      cond_true = flags_q.c;
            JC_NC:     cond_true = !flags_q.c;
            JC_N:      cond_true = flags_q.n;
            JC_NN:     cond_true = !flags_q.n;
            JC_V:      cond_true = flags_q.v;
            JC_NV:     cond_true = !flags_q.v;
            default:   cond_true = 1'b0;
        endcase
    end

    assign advance      = !i_pipe_stall && !mul_busy;
    assign branch_taken = !i_reset && !i_pipe_flush && advance &&
                          (i_opcode == OP_BRANCH) && cond_true;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            opcode_q <= '0;
            dr_q     <= '0;
            value_q  <= '0;
            flags_q  <= '0;
        end else if (i_pipe_flush) begin
            opcode_q <= OP_NOP;
            dr_q     <= '0;
            value_q  <= '0;
        end else if (!i_pipe_stall) begin
            if (mul_busy) begin
                opcode_q <= OP_NOP;
                dr_q     <= '0;
                value_q  <= '0;
            end else begin
                opcode_q <= i_opcode;
                dr_q     <= writes ? i_dr : 4'd0;
                value_q  <= result;
                flags_q  <= flags_d;
            end
        end
    end

    assign o_pipe_stall    = i_pipe_stall || mul_busy;
    assign o_pipe_flush    = i_pipe_flush || branch_taken;
    assign o_branch_taken  = branch_taken;
    assign o_branch_target = i_pc + i_target_address_offset;
    assign o_of1_reg       = (writes && !i_pipe_flush && !i_reset) ? i_dr : 4'd0;
    assign o_of1_data      = result;
    assign o_of2_reg       = dr_q;
    assign o_of2_data      = value_q;
    assign o_opcode        = opcode_q;
    assign o_dr            = dr_q;
    assign o_value         = value_q;
    assign o_flags         = flags_q;

endmodule
